pq_display_drv: RTL and testbench
=================================

PQ_DISPLAY_DRV -- requirements
Module: pq_display_drv

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles each digit stays selected (>=2).
REQ-002 Parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (>=2).
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port load  input  1  capture strobe for data1/data2, sampled each clk edge.
REQ-006 Port data1  input  8  priority-queue key byte; shown on upper two digits.
REQ-007 Port data2  input  8  priority-queue value byte; shown on lower two digits.
REQ-008 Port sigFULL  input  1  queue-full status.
REQ-009 Port sigEMPTY  input  1  queue-empty status.
REQ-010 Port red, green, blue  input  3 each  colour intensity levels 0..7.
REQ-011 Port an  output  4  digit enables, active-low, one-hot-low.
REQ-012 Port seg  output  7  segments, active-low, seg[6:0]=g,f,e,d,c,b,a.
REQ-013 Port dp  output  1  decimal point, active-low.
REQ-014 Port led_r, led_g, led_b  output  1 each  PWM colour drive, active-high.

Function
REQ-015 Capture: load=1 at edge -> disp_reg <= {data1,data2}, valid <= 1 same edge; load=0 -> hold.
REQ-016 valid never clears except by reset.
REQ-017 Refresh counter counts 0..REFRESH_DIV-1 then wraps to 0; at wrap, digit index idx (2 bits) increments, 3->0.
REQ-018 Digit map: idx0=data2[3:0], idx1=data2[7:4], idx2=data1[3:0], idx3=data1[7:4] (from disp_reg).
REQ-019 an registered: an[idx]=0, others 1, one cycle after idx changes.
REQ-020 seg registered, same cycle as an: hex decode of selected nibble, 0-F standard (0=7'b1000000, 8=7'b0000000, F=7'b0001110).
REQ-021 valid=0 -> seg=7'h7F and dp=1 while an keeps scanning.
REQ-022 dp=0 only when idx=2 and valid=1 and not blanked (key/value separator); else 1.
REQ-023 Blink: when sigFULL|sigEMPTY, blink counter counts 0..BLINK_DIV-1, toggles blink_phase at wrap.
REQ-024 When sigFULL=sigEMPTY=0, blink counter and blink_phase forced to 0 next edge.
REQ-025 blink_phase=1 -> seg=7'h7F, dp=1 (an unaffected).
REQ-026 PWM: 3-bit pwm_cnt increments every cycle, 7->0 wrap.
REQ-027 led_x registered = (pwm_cnt < x_level); level 0 -> always 0; level 7 -> high 7 of 8 cycles.
REQ-028 Colour levels sampled directly each cycle; change takes effect at next compare, no glitch beyond one cycle.
REQ-029 load coincident with refresh wrap: both act; the newly selected digit shows the new data one cycle later.
REQ-030 Sustained load=1: disp_reg tracks inputs every cycle.
REQ-031 No output is combinational from any input.

Reset
REQ-032 rst=1 asynchronously forces: disp_reg=0, valid=0, refresh cnt=0, idx=0, blink cnt=0, blink_phase=0, pwm_cnt=0.
REQ-033 rst=1 asynchronously forces outputs: an=4'b1111, seg=7'h7F, dp=1, led_r=led_g=led_b=0.
REQ-034 Reset mid-scan or mid-blink discards all state; first enabled digit after release is idx0 one cycle after release edge.

Verification (REFRESH_DIV=4, BLINK_DIV=8)
REQ-035 Reset then idle, no load -> an cycles 1110,1101,1011,0111 every 4 cycles; seg=7'h7F, dp=1 throughout.
REQ-036 load=1 with data1=8'hA5, data2=8'h3C for one cycle -> digits show C,3,5,A (seg 7'b1000110,7'b0110000,7'b0010010,7'b0001000); dp=0 only with an=1011.
REQ-037 sigEMPTY=1 held -> seg/dp blank for 8 cycles, shown 8 cycles, repeating; drop sigEMPTY -> display steady within 1 cycle after phase clears.
REQ-038 red=0, green=3, blue=7 -> over any 8 consecutive cycles led_r high 0, led_g 3, led_b 7.
REQ-039 Assert rst mid-scan with valid data -> outputs reach reset values without clock edge; after release, seg=7'h7F until next load.
REQ-040 load asserted on refresh-wrap edge with new data -> next selected digit shows new nibble, no stale digit shown.

Source files
------------

// File: rtl/pq_display_if.sv
// Signal bundle between the priority-queue status logic and the display driver.
// The master side supplies data, status and colour levels. The slave side drives
// the seven-segment digits and the RGB LED.
interface pq_display_if;
    logic       load;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       sigFULL;
    logic       sigEMPTY;
    logic [2:0] red;
    logic [2:0] green;
    logic [2:0] blue;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       led_r;
    logic       led_g;
    logic       led_b;

    modport master (
        output load, data1, data2, sigFULL, sigEMPTY, red, green, blue,
        input  an, seg, dp, led_r, led_g, led_b
    );

    modport slave (
        input  load, data1, data2, sigFULL, sigEMPTY, red, green, blue,
        output an, seg, dp, led_r, led_g, led_b
    );
endinterface

// File: rtl/pq_display_drv.sv
// Four-digit multiplexed seven-segment driver for a priority-queue entry.
// The key byte appears on the upper two digits and the value byte on the lower two.
// The decimal point on digit 2 separates key from value.
// While the queue is full or empty, the whole display blinks.
// A 3-bit PWM drives the RGB status LED.
// Every output is registered.
module pq_display_drv #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic         clk,
    input  logic         rst,
    pq_display_if.slave  bus
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Active-low hex font, bit order g,f,e,d,c,b,a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [15:0]   disp_reg;
    logic          valid;
    logic [RW-1:0] ref_cnt;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [2:0]    pwm_cnt;

    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic          led_r_q;
    logic          led_g_q;
    logic          led_b_q;

    logic [3:0]    nibble;
    logic          blanked;
    logic          status_alert;

    assign status_alert = bus.sigFULL | bus.sigEMPTY;
    assign blanked      = ~valid | blink_phase;

    // Pick the nibble for the digit currently selected by idx.
    always_comb begin
        nibble = 4'h0;
        case (idx)
            2'd0: nibble = disp_reg[3:0];
            2'd1: nibble = disp_reg[7:4];
            2'd2: nibble = disp_reg[11:8];
            default: nibble = disp_reg[15:12];
        endcase
    end

    // Capture the queue entry on load. Once loaded, the display stays valid until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_reg <= 16'h0000;
            valid    <= 1'b0;
        end else if (bus.load) begin
            disp_reg <= {bus.data1, bus.data2};
            valid    <= 1'b1;
        end
    end

    // Hold each digit for REFRESH_DIV cycles, then step to the next digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= 2'd0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    // Blink only while the queue is full or empty. Otherwise park the blinker so the display stays lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!status_alert) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BW'(1);
        end
    end

    // Free-running PWM phase shared by the three colour channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= 3'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;
        end
    end

    // Register the digit enable, segments and separator point from the current scan position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 4'b1111;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= ~(4'b0001 << idx);
            seg_q <= blanked ? 7'h7F : hex_to_seg(nibble);
            dp_q  <= ~((idx == 2'd2) & ~blanked);
        end
    end

    // LED channels: on while the PWM phase is below the requested level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r_q <= 1'b0;
            led_g_q <= 1'b0;
            led_b_q <= 1'b0;
        end else begin
            led_r_q <= (pwm_cnt < bus.red);
            led_g_q <= (pwm_cnt < bus.green);
            led_b_q <= (pwm_cnt < bus.blue);
        end
    end

    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.led_r = led_r_q;
    assign bus.led_g = led_g_q;
    assign bus.led_b = led_b_q;

endmodule

// File: tb/tb_pq_display_drv.sv
// Directed bench for pq_display_drv with REFRESH_DIV=4 and BLINK_DIV=8.
module tb_pq_display_drv;

    logic clk;
    logic rst;
    pq_display_if bus();

    pq_display_drv #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Edges since the last reset release, plus the expected display model.
    int          n = 0;
    logic [15:0] mdl_disp  = 16'h0;
    logic        mdl_valid = 1'b0;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;

    function automatic logic [6:0] font(input logic [3:0] v);
        logic [6:0] t [16];
        t[0]  = 7'b1000000; t[1]  = 7'b1111001; t[2]  = 7'b0100100; t[3]  = 7'b0110000;
        t[4]  = 7'b0011001; t[5]  = 7'b0010010; t[6]  = 7'b0000010; t[7]  = 7'b1111000;
        t[8]  = 7'b0000000; t[9]  = 7'b0010000; t[10] = 7'b0001000; t[11] = 7'b0000011;
        t[12] = 7'b1000110; t[13] = 7'b0100001; t[14] = 7'b0000110; t[15] = 7'b0001110;
        return t[v];
    endfunction

    // Advance one clock and work out what the outputs should show after that edge.
    // The output registers use the display contents as they were before the edge.
    task automatic step();
        logic [15:0] pd;
        logic        pv;
        int          ix;
        pd = mdl_disp;
        pv = mdl_valid;
        if (bus.load) begin
            mdl_disp  = {bus.data1, bus.data2};
            mdl_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        n++;
        ix      = ((n - 1) / 4) % 4;
        exp_an  = 4'(~(4'b0001 << ix));
        exp_seg = pv ? font(pd[ix*4 +: 4]) : 7'h7F;
        exp_dp  = (pv && ix == 2) ? 1'b0 : 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.an !== 4'b1111) $display("FAIL reset_an got %b want 1111", bus.an); else pass_cnt++;
        total_cnt++; if (bus.seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", bus.seg); else pass_cnt++;
        total_cnt++; if (bus.dp !== 1'b1) $display("FAIL reset_dp got %b want 1", bus.dp); else pass_cnt++;
        total_cnt++; if ({bus.led_r, bus.led_g, bus.led_b} !== 3'b000)
            $display("FAIL reset_led got %b want 000", {bus.led_r, bus.led_g, bus.led_b}); else pass_cnt++;
        rst = 1'b0;
        n = 0; mdl_disp = 16'h0; mdl_valid = 1'b0;
    endtask

    task automatic test_idle_scan();
        for (int i = 0; i < 16; i++) begin
            step();
            total_cnt++; if (bus.an !== exp_an) $display("FAIL idle_an edge %0d got %b want %b", n, bus.an, exp_an); else pass_cnt++;
            total_cnt++; if (bus.seg !== 7'h7F) $display("FAIL idle_seg edge %0d got %h want 7f", n, bus.seg); else pass_cnt++;
            total_cnt++; if (bus.dp !== 1'b1) $display("FAIL idle_dp edge %0d got %b want 1", n, bus.dp); else pass_cnt++;
        end
    endtask

    task automatic check_display(input string tag);
        total_cnt++; if (bus.an !== exp_an) $display("FAIL %s_an edge %0d got %b want %b", tag, n, bus.an, exp_an); else pass_cnt++;
        total_cnt++; if (bus.seg !== exp_seg) $display("FAIL %s_seg edge %0d got %b want %b", tag, n, bus.seg, exp_seg); else pass_cnt++;
        total_cnt++; if (bus.dp !== exp_dp) $display("FAIL %s_dp edge %0d got %b want %b", tag, n, bus.dp, exp_dp); else pass_cnt++;
    endtask

    task automatic test_load();
        bus.load = 1'b1; bus.data1 = 8'hA5; bus.data2 = 8'h3C;
        step();
        bus.load = 1'b0; bus.data1 = 8'h00; bus.data2 = 8'h00;
        check_display("load");
        for (int i = 0; i < 16; i++) begin
            step();
            check_display("load");
        end
        // Explicit hand values for the next digit (idx advances on edges 4j+1).
        while ((n % 4) != 0) step();
        step();
        begin
            int ix;
            logic [6:0] want;
            ix = ((n - 1) / 4) % 4;
            case (ix)
                0: want = 7'b1000110;
                1: want = 7'b0110000;
                2: want = 7'b0010010;
                default: want = 7'b0001000;
            endcase
            total_cnt++; if (bus.seg !== want) $display("FAIL load_digit%0d got %b want %b", ix, bus.seg, want); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            bus.load  = 1'b1;
            bus.data1 = 8'(8'h17 * (i + 1));
            bus.data2 = 8'(8'h29 * (i + 3));
            step();
            check_display("b2b");
        end
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_display("b2b_hold");
        end
    endtask

    task automatic test_load_wrap();
        while ((n % 4) != 3) step();
        bus.load = 1'b1; bus.data1 = 8'h96; bus.data2 = 8'h1E;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_display("wrap");
        end
    endtask

    task automatic test_blink();
        bus.sigEMPTY = 1'b1;
        for (int k = 0; k < 28; k++) begin
            logic blank;
            step();
            blank = ((k / 8) % 2) == 1;
            total_cnt++; if (bus.an !== exp_an) $display("FAIL blink_an k=%0d got %b want %b", k, bus.an, exp_an); else pass_cnt++;
            total_cnt++; if (bus.seg !== (blank ? 7'h7F : exp_seg))
                $display("FAIL blink_seg k=%0d got %b want %b", k, bus.seg, blank ? 7'h7F : exp_seg); else pass_cnt++;
            total_cnt++; if (bus.dp !== (blank ? 1'b1 : exp_dp))
                $display("FAIL blink_dp k=%0d got %b want %b", k, bus.dp, blank ? 1'b1 : exp_dp); else pass_cnt++;
        end
        bus.sigEMPTY = 1'b0;
        step();
        total_cnt++; if (bus.seg !== 7'h7F) $display("FAIL blink_drop_edge got %b want 1111111", bus.seg); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            step();
            check_display("blink_off");
        end
        bus.sigFULL = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic blank;
            step();
            blank = ((k / 8) % 2) == 1;
            total_cnt++; if (bus.seg !== (blank ? 7'h7F : exp_seg))
                $display("FAIL full_seg k=%0d got %b want %b", k, bus.seg, blank ? 7'h7F : exp_seg); else pass_cnt++;
        end
        bus.sigFULL = 1'b0;
        step();
        step();
        check_display("full_off");
    endtask

    task automatic pwm_case(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                            input int wr, input int wg, input int wb);
        int cr, cg, cb;
        bus.red = r; bus.green = g; bus.blue = b;
        step();
        cr = 0; cg = 0; cb = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            cr += int'(bus.led_r); cg += int'(bus.led_g); cb += int'(bus.led_b);
        end
        total_cnt++; if (cr !== wr) $display("FAIL pwm_r level %0d got %0d want %0d", r, cr, wr); else pass_cnt++;
        total_cnt++; if (cg !== wg) $display("FAIL pwm_g level %0d got %0d want %0d", g, cg, wg); else pass_cnt++;
        total_cnt++; if (cb !== wb) $display("FAIL pwm_b level %0d got %0d want %0d", b, cb, wb); else pass_cnt++;
    endtask

    task automatic test_pwm();
        pwm_case(3'd0, 3'd3, 3'd7, 0, 3, 7);
        pwm_case(3'd7, 3'd0, 3'd1, 7, 0, 1);
        pwm_case(3'd5, 3'd2, 3'd4, 5, 2, 4);
    endtask

    task automatic test_reset_mid();
        bus.red = 3'd7; bus.green = 3'd7; bus.blue = 3'd7;
        for (int i = 0; i < 6; i++) step();
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (bus.an !== 4'b1111) $display("FAIL midrst_an got %b want 1111", bus.an); else pass_cnt++;
        total_cnt++; if (bus.seg !== 7'h7F) $display("FAIL midrst_seg got %h want 7f", bus.seg); else pass_cnt++;
        total_cnt++; if (bus.dp !== 1'b1) $display("FAIL midrst_dp got %b want 1", bus.dp); else pass_cnt++;
        total_cnt++; if ({bus.led_r, bus.led_g, bus.led_b} !== 3'b000)
            $display("FAIL midrst_led got %b want 000", {bus.led_r, bus.led_g, bus.led_b}); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0; mdl_disp = 16'h0; mdl_valid = 1'b0;
        bus.red = 3'd0; bus.green = 3'd0; bus.blue = 3'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_display("after_rst");
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.load = 1'b0; bus.data1 = 8'h00; bus.data2 = 8'h00;
        bus.sigFULL = 1'b0; bus.sigEMPTY = 1'b0;
        bus.red = 3'd0; bus.green = 3'd0; bus.blue = 3'd0;
        test_reset();
        test_idle_scan();
        test_load();
        test_back_to_back();
        test_load_wrap();
        test_blink();
        test_pwm();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
